// File: rtl/pbpix_zrl_expander_if.sv
// Token-in / pixel-out bundle for the zero-run-length expander.
//   tok_rdy/tok_ack   token handshake; transfer when both are high
//   tok_run           1 = zero-run token, 0 = literal token
//   tok_data          literal value, or run length minus one in the low CW bits
//   pix_rdy/pix_ack   pixel handshake; transfer when both are high
//   pix_zero          pixel is zero (pix_data is then 0)
//   pix_data          pixel value
//   pix_last          pixel is the last one of its frame
// master: token producer and pixel consumer. slave: the expander.
interface pbpix_zrl_expander_if #(
   parameter int unsigned DW = 8
) ();
   logic          tok_rdy;
   logic          tok_ack;
   logic          tok_run;
   logic [DW-1:0] tok_data;
   logic          pix_rdy;
   logic          pix_ack;
   logic          pix_zero;
   logic [DW-1:0] pix_data;
   logic          pix_last;

   modport master (
      output tok_rdy, tok_run, tok_data, pix_ack,
      input  tok_ack, pix_rdy, pix_zero, pix_data, pix_last
   );

   modport slave (
      input  tok_rdy, tok_run, tok_data, pix_ack,
      output tok_ack, pix_rdy, pix_zero, pix_data, pix_last
   );
endinterface

// File: rtl/pbpix_zrl_expander.sv
// Zero-run-length decoder. Accepts literal or zero-run tokens and emits one
// pixel per handshake from a single registered output stage.
//   i_clk   clock, rising edge
//   i_rstn  asynchronous active-low reset
//   bus     slave side of pbpix_zrl_expander_if (token in, pixel out)
module pbpix_zrl_expander #(
   parameter int unsigned DW   = 8,
   parameter int unsigned CW   = 8,
   parameter int unsigned NPIX = 1024
) (
   input logic                 i_clk,
   input logic                 i_rstn,
   pbpix_zrl_expander_if.slave bus
);
   localparam int unsigned PCW = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [PCW-1:0] LastIdx = PCW'(NPIX - 1);

   typedef enum logic [1:0] {StEmpty, StLit, StRun} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   run_cnt_q, run_cnt_d;
   logic [PCW-1:0]  pix_cnt_q, pix_cnt_d;
   logic            pix_rdy_q, pix_rdy_d;
   logic            pix_zero_q, pix_zero_d;
   logic [DW-1:0]   pix_data_q, pix_data_d;
   logic            pix_last_q, pix_last_d;
   logic            tok_ack;
   logic            free;
   logic            pix_hs;
   logic            next_last;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= StEmpty;
         run_cnt_q  <= '0;
         pix_cnt_q  <= '0;
         pix_rdy_q  <= 1'b0;
         pix_zero_q <= 1'b0;
         pix_data_q <= '0;
         pix_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_cnt_q  <= run_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         pix_rdy_q  <= pix_rdy_d;
         pix_zero_q <= pix_zero_d;
         pix_data_q <= pix_data_d;
         pix_last_q <= pix_last_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      run_cnt_d  = run_cnt_q;
      pix_rdy_d  = pix_rdy_q;
      pix_zero_d = pix_zero_q;
      pix_data_d = pix_data_q;
      pix_last_d = pix_last_q;
      tok_ack    = 1'b0;

      pix_hs = pix_rdy_q && bus.pix_ack;
      free   = !pix_rdy_q || bus.pix_ack;

      // pix_cnt indexes the pixel currently held; after a handshake the next
      // loaded pixel takes the following index.
      if (pix_hs) begin
         pix_cnt_d = (pix_cnt_q == LastIdx) ? '0 : pix_cnt_q + PCW'(1);
      end else begin
         pix_cnt_d = pix_cnt_q;
      end
      next_last = (pix_cnt_d == LastIdx);

      if (free) begin
         if (run_cnt_q != '0) begin
            // Remaining zeros of a run take priority over new tokens.
            pix_rdy_d  = 1'b1;
            pix_zero_d = 1'b1;
            pix_data_d = '0;
            pix_last_d = next_last;
            run_cnt_d  = run_cnt_q - CW'(1);
            state_d    = StRun;
         end else begin
            tok_ack = 1'b1;
            if (bus.tok_rdy) begin
               pix_rdy_d  = 1'b1;
               pix_last_d = next_last;
               if (bus.tok_run) begin
                  pix_zero_d = 1'b1;
                  pix_data_d = '0;
                  run_cnt_d  = bus.tok_data[CW-1:0];
                  state_d    = StRun;
               end else begin
                  pix_zero_d = (bus.tok_data == '0);
                  pix_data_d = bus.tok_data;
                  state_d    = StLit;
               end
            end else begin
               pix_rdy_d = 1'b0;
               state_d   = StEmpty;
            end
         end
      end
   end

   assign bus.tok_ack  = tok_ack;
   assign bus.pix_rdy  = pix_rdy_q;
   assign bus.pix_zero = pix_zero_q;
   assign bus.pix_data = pix_data_q;
   assign bus.pix_last = pix_last_q;
endmodule

// File: tb/tb_pbpix_zrl_expander.sv
// Self-checking bench for pbpix_zrl_expander. A negedge monitor keeps a queue
// of undelivered pixels built from accepted tokens and checks every cycle.
module tb_pbpix_zrl_expander;
   localparam int unsigned DW   = 8;
   localparam int unsigned CW   = 8;
   localparam int unsigned NPIX = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          zero;
   } pix_t;

   logic clk;
   logic rstn;
   int   total = 0;
   int   bad   = 0;
   pix_t q[$];
   int   fcnt = 0;
   int   delivered = 0;
   bit   ack_rand = 0;
   bit   ack_q[$];

   pbpix_zrl_expander_if #(.DW(DW)) bus ();

   pbpix_zrl_expander #(
      .DW   (DW),
      .CW   (CW),
      .NPIX (NPIX)
   ) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // pix_ack driver: scripted values first, else random or always-high.
   initial begin
      bus.pix_ack = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ack_q.size() != 0) bus.pix_ack = ack_q.pop_front();
         else if (ack_rand) bus.pix_ack = ($urandom_range(0, 2) != 0);
         else bus.pix_ack = 1'b1;
      end
   end

   // Monitor / reference model.
   initial begin
      bit   stall_prev;
      logic [DW+1:0] prev;
      pix_t e;
      bit   exp_ack;
      stall_prev = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            q.delete();
            fcnt = 0;
            stall_prev = 1'b0;
            continue;
         end
         chk("pix_rdy", {31'd0, bus.pix_rdy}, {31'd0, q.size() != 0});
         exp_ack = (q.size() == 0) || (q.size() == 1 && bus.pix_ack);
         chk("tok_ack", {31'd0, bus.tok_ack}, {31'd0, exp_ack});
         if (stall_prev)
            chk("stall_hold", {22'd0, bus.pix_zero, bus.pix_last, bus.pix_data}, {22'd0, prev});
         if (bus.pix_rdy && bus.pix_ack && q.size() != 0) begin
            e = q.pop_front();
            chk("pix_data", {24'd0, bus.pix_data}, {24'd0, e.data});
            chk("pix_zero", {31'd0, bus.pix_zero}, {31'd0, e.zero});
            chk("pix_last", {31'd0, bus.pix_last}, {31'd0, fcnt == NPIX - 1});
            fcnt = (fcnt + 1) % NPIX;
            delivered++;
         end
         stall_prev = bus.pix_rdy && !bus.pix_ack;
         prev = {bus.pix_zero, bus.pix_last, bus.pix_data};
         if (bus.tok_rdy && bus.tok_ack) begin
            if (bus.tok_run) begin
               for (int i = 0; i <= int'(bus.tok_data[CW-1:0]); i++)
                  q.push_back('{data: '0, zero: 1'b1});
            end else begin
               q.push_back('{data: bus.tok_data, zero: (bus.tok_data == 0)});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
   task automatic send_tok(input bit run, input logic [DW-1:0] data);
      bit got;
      got = 1'b0;
      bus.tok_run  = run;
      bus.tok_data = data;
      bus.tok_rdy  = 1'b1;
      for (int n = 0; n < 600 && !got; n++) begin
         @(negedge clk);
         got = bus.tok_ack;
         tick();
      end
      bus.tok_rdy = 1'b0;
      if (!got) chk("tok_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 3000 && !done; n++) begin
         @(negedge clk);
         #1;
         done = (q.size() == 0);
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
      tick();
   endtask

   initial begin
      int d0;
      rstn = 1'b0;
      bus.tok_rdy  = 1'b0;
      bus.tok_run  = 1'b0;
      bus.tok_data = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_pix_rdy", {31'd0, bus.pix_rdy}, 32'd0);
      chk("rst_pix_zero", {31'd0, bus.pix_zero}, 32'd0);
      chk("rst_pix_data", {24'd0, bus.pix_data}, 32'd0);
      chk("rst_pix_last", {31'd0, bus.pix_last}, 32'd0);
      rstn = 1'b1;
      tick();

      // Literals back to back, including a zero literal.
      send_tok(1'b0, 8'h12);
      send_tok(1'b0, 8'h00);
      send_tok(1'b0, 8'h7F);
      drain();

      // Run of 4 zeros followed by a literal with no bubble.
      send_tok(1'b1, 8'd3);
      send_tok(1'b0, 8'h55);
      drain();

      // Backpressure during a 3-zero run; literal must wait.
      d0 = delivered;
      ack_q.push_back(1'b1);
      ack_q.push_back(1'b0);
      ack_q.push_back(1'b0);
      ack_q.push_back(1'b1);
      ack_q.push_back(1'b1);
      send_tok(1'b1, 8'd2);
      send_tok(1'b0, 8'h33);
      drain();
      chk("bp_count", delivered - d0, 32'd4);

      // Maximum run length.
      d0 = delivered;
      send_tok(1'b1, 8'd255);
      send_tok(1'b0, 8'h01);
      drain();
      chk("maxrun_count", delivered - d0, 32'd257);

      // Asynchronous reset in the middle of a run.
      send_tok(1'b1, 8'd10);
      repeat (5) tick();
      rstn = 1'b0;
      #1;
      chk("async_pix_rdy", {31'd0, bus.pix_rdy}, 32'd0);
      chk("async_pix_zero", {31'd0, bus.pix_zero}, 32'd0);
      chk("async_pix_data", {24'd0, bus.pix_data}, 32'd0);
      chk("async_pix_last", {31'd0, bus.pix_last}, 32'd0);
      repeat (2) tick();
      rstn = 1'b1;
      tick();

      // Frame boundaries: run of 5 then 11 literals -> last on pixel 8 and 16.
      d0 = delivered;
      send_tok(1'b1, 8'd4);
      for (int i = 0; i < 11; i++) send_tok(1'b0, 8'(8'hA0 + i));
      drain();
      chk("frame_count", delivered - d0, 32'd16);

      // Randomized tokens with random backpressure and idle gaps.
      ack_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         if ($urandom_range(0, 2) == 0) begin
            send_tok(1'b1, ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)));
         end else begin
            send_tok(1'b0, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
         end
      end
      ack_rand = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
